led_pattern_ctrl: RTL and testbench

Controller that sequences the board LEDs from a prescaled step tick. It replaces the divided-clock approach with a single-clock enable.
- Two debounced buttons drive a run/pause/stop state machine.
- Two switches select the step operation (rotate or count) and the direction.
- Sits under top, alongside the gate logic, and drives led[3:0] directly.

---
 rtl/led_ctrl_pkg.sv | 20 ++
 rtl/btn_debounce.sv | 56 +++++
 rtl/led_pattern_ctrl.sv | 139 +++++++++++++
 tb/tb_led_pattern_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared encodings for the LED pattern controller: FSM states, switch meanings
// and the LED values loaded on entry to RUN.
package led_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'b00;
  localparam state_t ST_RUN   = 2'b01;
  localparam state_t ST_PAUSE = 2'b10;

  localparam logic MODE_ROT = 1'b0;
  localparam logic MODE_CNT = 1'b1;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  localparam logic [3:0] LED_ROT_INIT = 4'b0001;
  localparam logic [3:0] LED_CNT_INIT = 4'b0000;

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-FF synchronizer -> stability counter; emits a one-cycle
// press pulse on an accepted 0->1 transition (release is silent).
module btn_debounce #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q counts consecutive cycles the synchronized level has differed from
  // the accepted one; any return to the accepted level restarts it.
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED sequencer: debounced run/pause/stop buttons, prescaled step enable,
// rotate or binary-count pattern selected by synchronized switches.
//   state    | meaning
//   ST_IDLE  | stopped, led cleared, prescaler cleared
//   ST_RUN   | prescaler counting, pattern steps on each tick
//   ST_PAUSE | prescaler and led frozen, resume keeps prescaler phase
module led_pattern_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int TICK_DIV   = 50000000,
  parameter int DEB_CYCLES = 1000000,
  parameter int N_LED      = 4
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             btnu,
  input  logic             btnd,
  input  logic             sw0,
  input  logic             sw1,
  output logic [N_LED-1:0] led,
  output logic             busy,
  output logic             step_tick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic             press_u, press_d;
  logic             unused_btnu_level, unused_btnd_level;
  logic [1:0]       sw_s1_q, sw_s2_q;
  logic             sw_dir, sw_mode;
  state_t           state_q, state_d;
  logic [N_LED-1:0] led_q, led_d, step_led;
  logic [PW-1:0]    presc_q, presc_d;
  logic             busy_q;
  logic             tick_apply;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .raw   (btnu),
    .level (unused_btnu_level),
    .press (press_u)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .raw   (btnd),
    .level (unused_btnd_level),
    .press (press_d)
  );

  assign sw_dir  = sw_s2_q[0];
  assign sw_mode = sw_s2_q[1];

  // Any button press in the tick cycle swallows that step.
  assign tick_apply = (state_q == ST_RUN) && (presc_q == PRESC_LAST) &&
                      !press_u && !press_d;

  always_comb begin
    step_led = led_q;
    if (sw_mode == MODE_ROT) begin
      if (led_q == '0)
        step_led = N_LED'(LED_ROT_INIT);
      else if (sw_dir == DIR_UP)
        step_led = {led_q[N_LED-2:0], led_q[N_LED-1]};
      else
        step_led = {led_q[0], led_q[N_LED-1:1]};
    end else if (sw_dir == DIR_UP) begin
      step_led = led_q + N_LED'(1);
    end else begin
      step_led = led_q - N_LED'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    presc_d = presc_q;
    if (press_d) begin
      state_d = ST_IDLE;
      led_d   = '0;
      presc_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (press_u) begin
            state_d = ST_RUN;
            presc_d = '0;
            led_d   = (sw_mode == MODE_CNT) ? N_LED'(LED_CNT_INIT)
                                            : N_LED'(LED_ROT_INIT);
          end
        end
        ST_RUN: begin
          if (press_u) begin
            state_d = ST_PAUSE;
          end else if (tick_apply) begin
            led_d   = step_led;
            presc_d = '0;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        ST_PAUSE: begin
          if (press_u) state_d = ST_RUN;
        end
        default: begin
          state_d = ST_IDLE;
          led_d   = '0;
          presc_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      state_q <= ST_IDLE;
      led_q   <= '0;
      presc_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      sw_s1_q <= {sw1, sw0};
      sw_s2_q <= sw_s1_q;
      state_q <= state_d;
      led_q   <= led_d;
      presc_q <= presc_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign led       = led_q;
  assign busy      = busy_q;
  assign step_tick = tick_apply;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl: directed scenarios plus random button/switch
// activity, every cycle compared against a behavioural reference model.
module tb_led_pattern_ctrl;

  localparam int TD  = 4;
  localparam int DEB = 3;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;

  logic       CLK = 1'b0;
  logic       RSTN = 1'b0;
  logic       btnu = 1'b0, btnd = 1'b0, sw0 = 1'b0, sw1 = 1'b0;
  logic [3:0] led;
  logic       busy, step_tick;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  led_pattern_ctrl #(.TICK_DIV(TD), .DEB_CYCLES(DEB), .N_LED(4)) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .btnu      (btnu),
    .btnd      (btnd),
    .sw0       (sw0),
    .sw1       (sw1),
    .led       (led),
    .busy      (busy),
    .step_tick (step_tick)
  );

  // Reference model: inputs indexed 0=btnu 1=btnd 2=sw0 3=sw1
  int sy1[4], sy2[4];
  int lvl[2], run_len[2], prs[2];
  int m_st, m_led, m_cnt;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int led_step(input int v, input int mode, input int dir);
    if (mode == 0) begin
      if (v == 0) return 1;
      if (dir == 0) return ((v * 2) % 16) + (v / 8);
      return (v / 2) + ((v % 2) * 8);
    end
    if (dir == 0) return (v + 1) % 16;
    return (v + 15) % 16;
  endfunction

  function automatic int exp_tick();
    return (m_st == M_RUN && m_cnt == TD - 1 && prs[0] == 0 && prs[1] == 0) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin sy1[i] = 0; sy2[i] = 0; end
    for (int b = 0; b < 2; b++) begin lvl[b] = 0; run_len[b] = 0; prs[b] = 0; end
    m_st = M_IDLE; m_led = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    int raw[4];
    int pu, pd, tk;
    raw[0] = int'(btnu); raw[1] = int'(btnd); raw[2] = int'(sw0); raw[3] = int'(sw1);
    pu = prs[0];
    pd = prs[1];
    tk = exp_tick();
    if (pd != 0) begin
      m_st = M_IDLE; m_led = 0; m_cnt = 0;
    end else if (pu != 0) begin
      if (m_st == M_IDLE) begin
        m_st = M_RUN; m_cnt = 0; m_led = (sy2[3] == 1) ? 0 : 1;
      end else if (m_st == M_RUN) m_st = M_PAUSE;
      else m_st = M_RUN;
    end else if (m_st == M_RUN) begin
      if (tk != 0) begin
        m_led = led_step(m_led, sy2[3], sy2[2]);
        m_cnt = 0;
      end else m_cnt++;
    end
    for (int b = 0; b < 2; b++) begin
      prs[b] = 0;
      if (sy2[b] != lvl[b]) begin
        run_len[b]++;
        if (run_len[b] == DEB) begin
          lvl[b] = sy2[b]; run_len[b] = 0; prs[b] = sy2[b];
        end
      end else run_len[b] = 0;
    end
    for (int i = 0; i < 4; i++) begin sy2[i] = sy1[i]; sy1[i] = raw[i]; end
  endtask

  task automatic cycle();
    @(posedge CLK);
    if (RSTN) model_edge(); else model_reset();
    #1;
    chk("led", int'(led), m_led);
    chk("busy", int'(busy), (m_st != M_IDLE) ? 1 : 0);
    chk("step_tick", int'(step_tick), exp_tick());
  endtask

  task automatic hold_btnu(input int n);
    btnu = 1'b1; repeat (n) cycle();
    btnu = 1'b0; repeat (n) cycle();
  endtask

  task automatic hold_btnd(input int n);
    btnd = 1'b1; repeat (n) cycle();
    btnd = 1'b0; repeat (n) cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    bit hit;
    model_reset();
    #1;
    chk("rst_led", int'(led), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_tick", int'(step_tick), 0);
    repeat (3) cycle();
    RSTN = 1'b1;
    repeat (50) cycle();

    // clean press, rotate left: busy 6 cycles after raw edge
    sw1 = 1'b0; sw0 = 1'b0;
    btnu = 1'b1;
    k = 0;
    hit = 0;
    for (int i = 1; i <= 20 && !hit; i++) begin
      cycle();
      if (busy) begin k = i; hit = 1; end
    end
    chk("press_latency", k, 6);
    chk("led_load_rot", int'(led), 1);
    repeat (3) cycle();
    btnu = 1'b0;
    repeat (25) cycle();

    // count down from 0000, then flip to up mid-run
    hold_btnd(8);
    sw1 = 1'b1; sw0 = 1'b1;
    repeat (3) cycle();
    hold_btnu(8);
    repeat (6) cycle();
    sw0 = 1'b0;
    repeat (14) cycle();

    // bounced press, then pause and resume
    hold_btnd(8);
    sw1 = 1'b0;
    btnu = 1'b1; repeat (2) cycle();
    btnu = 1'b0; cycle();
    btnu = 1'b1; repeat (10) cycle();
    btnu = 1'b0; repeat (6) cycle();
    hold_btnu(7);
    repeat (10) cycle();
    hold_btnu(8);
    repeat (12) cycle();

    // simultaneous start/stop while running
    btnu = 1'b1; btnd = 1'b1;
    repeat (8) cycle();
    btnu = 1'b0; btnd = 1'b0;
    repeat (8) cycle();

    // async reset mid-run at led=0100
    sw0 = 1'b0;
    hold_btnu(8);
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (led == 4'b0100) hit = 1;
      else cycle();
    end
    chk("reach_0100", int'(hit), 1);
    #2 RSTN = 1'b0;
    #1;
    model_reset();
    chk("async_led", int'(led), 0);
    chk("async_busy", int'(busy), 0);
    repeat (3) cycle();
    RSTN = 1'b1;
    repeat (20) cycle();

    // random activity
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 5) == 0)  btnu = ~btnu;
      if ($urandom_range(0, 59) == 0) btnd = ~btnd;
      if ($urandom_range(0, 39) == 0) sw0  = ~sw0;
      if ($urandom_range(0, 49) == 0) sw1  = ~sw1;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
